// File: rtl/dsp_addsub_pipe.sv
// Pipelined add/sub/accumulate unit: one 16-bit slice per stage with the
// inter-slice carry registered, a global stall on output backpressure.
module dsp_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] acc_out
);

  localparam int LAT = WIDTH / 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Stage k holds slices 0..k of the result plus the full operands of its beat.
  logic [LAT-1:0]   st_valid;
  logic [LAT-1:0]   st_carry;
  op_e              st_op  [LAT];
  logic [WIDTH-1:0] st_a   [LAT];
  logic [WIDTH-1:0] st_b   [LAT];
  logic [WIDTH-1:0] st_sum [LAT];

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             advance;
  logic             acc_busy;
  logic [WIDTH-1:0] nxt_sum [LAT];
  logic [LAT-1:0]   nxt_carry;

  // Operand B after op decode: inverted for SUB, the accumulator for ACC,
  // zero for LOAD so the LOAD beat carries no carry or overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    b_eff = b_in;
    cin   = 1'b0;
    unique case (op_e'(op))
      OP_ADD:  b_eff = b_in;
      OP_SUB:  begin b_eff = ~b_in; cin = 1'b1; end
      OP_ACC:  b_eff = acc;
      OP_LOAD: b_eff = '0;
    endcase
  end

  always_comb begin
    nxt_sum[0] = '0;
    {nxt_carry[0], nxt_sum[0][15:0]} =
      {1'b0, a_in[15:0]} + {1'b0, b_eff[15:0]} + 17'(cin);
    for (int k = 1; k < LAT; k++) begin
      nxt_sum[k] = st_sum[k-1];
      {nxt_carry[k], nxt_sum[k][16*k +: 16]} =
        {1'b0, st_a[k-1][16*k +: 16]} + {1'b0, st_b[k-1][16*k +: 16]} +
        17'(st_carry[k-1]);
    end
  end

  // Any ACC/LOAD in flight blocks new beats so ACC always reads a settled acc.
  always_comb begin
    acc_busy = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (st_valid[k] && (st_op[k] == OP_ACC || st_op[k] == OP_LOAD)) acc_busy = 1'b1;
    end
  end

  assign out_valid = st_valid[LAT-1];
  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance && !acc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: stage data is reset along with the valids because sum,
      // carry_out and overflow must read 0 the moment rst_n falls.
      st_valid <= '0;
      st_carry <= '0;
      for (int k = 0; k < LAT; k++) begin
        st_op[k]  <= OP_ADD;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
      end
    end else if (advance) begin
      // NOTE: non-blocking assignments so each stage captures its
      // neighbour's pre-edge value and the shift is order-independent.
      st_valid[0] <= in_valid && in_ready;
      st_op[0]    <= op_e'(op);
      st_a[0]     <= a_in;
      st_b[0]     <= b_eff;
      st_sum[0]   <= nxt_sum[0];
      st_carry[0] <= nxt_carry[0];
      for (int k = 1; k < LAT; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_op[k]    <= st_op[k-1];
        st_a[k]     <= st_a[k-1];
        st_b[k]     <= st_b[k-1];
        st_sum[k]   <= nxt_sum[k];
        st_carry[k] <= nxt_carry[k];
      end
    end
  end

  // The accumulator commits only when its ACC/LOAD result leaves the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      if (st_op[LAT-1] == OP_ACC)  acc <= st_sum[LAT-1];
      if (st_op[LAT-1] == OP_LOAD) acc <= st_a[LAT-1];
    end
  end

  assign sum       = st_sum[LAT-1];
  assign acc_out   = acc;
  assign carry_out = st_carry[LAT-1] && (st_op[LAT-1] != OP_LOAD);
  assign overflow  = (st_op[LAT-1] != OP_LOAD) &&
                     (st_a[LAT-1][WIDTH-1] == st_b[LAT-1][WIDTH-1]) &&
                     (st_sum[LAT-1][WIDTH-1] != st_a[LAT-1][WIDTH-1]);

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Self-checking bench for dsp_addsub_pipe: arithmetic reference model with a
// beat queue, per-cycle compare, directed corner cases and a WIDTH=64 build.
module tb_dsp_addsub_pipe;

  localparam int W   = 32;
  localparam int LAT = W / 16;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a_in, b_in, sum, acc_out;
  logic         carry_out, overflow;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [1:0]   w_op;
  logic [63:0]  w_a, w_b, w_sum, w_acc;
  logic         w_carry, w_ovf;

  always #5 clk = ~clk;

  dsp_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .acc_out(acc_out)
  );

  dsp_addsub_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a_in(w_a), .b_in(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .carry_out(w_carry), .overflow(w_ovf), .acc_out(w_acc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    int           age;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_acc;

  // Result from plain integer arithmetic: carry is "no wrap" / "a >= b",
  // overflow is "true signed result outside the W-bit range".
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, b, acc);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr;
    e.op = o; e.a = a; e.age = 0;
    ua = longint'(a);
    sa = longint'($signed(a));
    ub = (o == 2'b10) ? longint'(acc) : longint'(b);
    sb = (o == 2'b10) ? longint'($signed(acc)) : longint'($signed(b));
    case (o)
      2'b01:   begin r = ua - ub; e.c = (ua >= ub); sr = sa - sb; end
      2'b11:   begin r = ua; e.c = 1'b0; sr = sa; end
      default: begin r = ua + ub; e.c = (r >= (longint'(1) <<< W)); sr = sa + sb; end
    endcase
    e.sum = W'(r);
    e.v   = (o != 2'b11) && (sr > SMAX || sr < SMIN);
    return e;
  endfunction

  // Per-cycle compare; handshakes sampled at negedge take effect next posedge.
  always @(negedge clk) begin : monitor
    logic acc_inflight, stall, exp_valid;
    if (rst_n) begin
      stall        = out_valid && !out_ready;
      exp_valid    = (q.size() != 0) && (q[0].age >= LAT - 1);
      acc_inflight = 1'b0;
      foreach (q[i]) if (q[i].op[1]) acc_inflight = 1'b1;
      check("out_valid", out_valid, exp_valid);
      check("acc_out", acc_out, m_acc);
      check("in_ready", in_ready, !stall && !acc_inflight);
      if (out_valid && exp_valid) begin
        if (q[0].op != 2'b11) check("sum", sum, q[0].sum);
        check("carry_out", carry_out, q[0].c);
        check("overflow", overflow, q[0].v);
        if (out_ready) begin
          if (q[0].op == 2'b10) m_acc = q[0].sum;
          if (q[0].op == 2'b11) m_acc = q[0].a;
          void'(q.pop_front());
          n_pop++;
        end
      end
      if (!stall) foreach (q[i]) q[i].age++;
      if (in_valid && in_ready) q.push_back(model(op, a_in, b_in, m_acc));
    end
  end

  task automatic drive(input logic [1:0] o, input logic [W-1:0] a, b);
    op = o; a_in = a; b_in = b;
  endtask

  // Holds the beat until the negedge before its accepting edge.
  task automatic offer(input logic [1:0] o, input logic [W-1:0] a, b);
    @(posedge clk); #1;
    drive(o, a, b);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
  endtask

  // Call right after offer(): passes the accept edge, then counts cycles to out_valid.
  task automatic wait_result(output int lat);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic do_beat(input logic [1:0] o, input logic [W-1:0] a, b, output int lat);
    offer(o, a, b);
    wait_result(lat);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    check("drain_empty", q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, pops0, r;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; m_acc = '0;
    drive(2'b00, '0, '0);
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_op = 2'b00; w_a = '0; w_b = '0;

    // Reset state, then a beat waiting at release is taken on the first edge.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_acc", acc_out, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, 0);
    check("rst_ovf", overflow, 0);
    drive(2'b00, 32'h0000_FFFF, 32'h0000_0001);
    in_valid = 1'b1;
    #6 rst_n = 1'b1;
    #1 check("first_in_ready", in_ready, 1);
    wait_result(lat);
    check("slice_carry_lat", lat, 2);
    check("slice_carry_sum", sum, 32'h0001_0000);
    check("slice_carry_c", carry_out, 0);
    check("slice_carry_v", overflow, 0);

    do_beat(2'b01, 32'h8000_0000, 32'h0000_0001, lat);
    check("sub_ovf_lat", lat, 2);
    check("sub_ovf_sum", sum, 32'h7FFF_FFFF);
    check("sub_ovf_v", overflow, 1);
    check("sub_ovf_c", carry_out, 1);
    do_beat(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    check("add_wrap_sum", sum, 0);
    check("add_wrap_c", carry_out, 1);
    check("add_wrap_v", overflow, 0);

    // Accumulator chain 5 -> 8 -> 6.
    do_beat(2'b11, 32'd5, 32'h1234_5678, lat);
    check("load_busy", in_ready, 0);
    @(posedge clk); #1 check("acc_after_load", acc_out, 5);
    do_beat(2'b10, 32'd3, 32'hDEAD_BEEF, lat);
    check("acc3_busy", in_ready, 0);
    check("acc3_sum", sum, 8);
    @(posedge clk); #1 check("acc_after_acc3", acc_out, 8);
    do_beat(2'b10, 32'hFFFF_FFFE, 32'h0, lat);
    check("accm2_sum", sum, 6);
    check("accm2_c", carry_out, 1);
    @(posedge clk); #1 check("acc_after_accm2", acc_out, 6);

    // Eight back-to-back ADDs with a three-cycle output stall mid-stream.
    pops0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) offer(2'b00, pick(), pick());
        @(posedge clk); #1 in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_pop - pops0, 8);

    // Reset with two beats in flight discards them and clears acc.
    offer(2'b00, 32'h1111_1111, 32'h2222_2222);
    offer(2'b01, 32'h3333_3333, 32'h0000_0001);
    @(posedge clk);
    #2 check("pre_rst_out_valid", out_valid, 1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_acc", acc_out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sum", sum, 0);
    q.delete();
    m_acc = '0;
    #10 rst_n = 1'b1;
    pops0 = n_pop;
    repeat (6) @(negedge clk);
    check("no_beat_after_rst", n_pop - pops0, 0);

    // Randomised mix with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 9);
      drive((r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11, pick(), pick());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // WIDTH=64: carry ripples across the 32-bit boundary, latency 4.
    @(posedge clk); #1;
    w_op = 2'b00; w_a = 64'h0000_0000_FFFF_FFFF; w_b = 64'd1; w_in_valid = 1'b1;
    @(negedge clk);
    check("w64_in_ready", w_in_ready, 1);
    @(posedge clk); #1 w_in_valid = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (w_out_valid) break;
    end
    check("w64_lat", lat, 4);
    check("w64_sum", w_sum, 64'h0000_0001_0000_0000);
    check("w64_c", w_carry, 0);
    check("w64_v", w_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
